// File: rtl/set_bit_arbiter.sv
// set_bit_arbiter
//   Arbitrates ownership of a shared set_bit writer between a header
//   requester and a component requester. The current owner's write and
//   flush strobes are registered onto the sb_* bus. A one-cycle DRAIN state
//   after each release lets the final registered write land before the next
//   owner is granted.
//
//   Build option: define SET_BIT_ARB_ROUND_ROBIN_EN to settle simultaneous
//   requests in favour of the requester that was not the last owner.
//   Without it, the header always wins a tie.
//
// Ports
//   clock, reset_n                     sole clock (rising edge); async active-low reset
//   hdr_req / cmp_req                  request ownership
//   hdr_done / cmp_done                owner releases ownership
//   hdr_enable/flush, cmp_enable/flush write / flush strobes
//   hdr_val/size_of_bit, cmp_val/...   write payload and bit count
//   hdr_grant / cmp_grant              ownership indication
//   sb_enable, sb_flush, sb_val,
//   sb_size_of_bit                     registered drive to set_bit
//   busy                               arbiter not idle
//   grant_bit_count                    bits accepted under the current/last grant
//   protocol_err                       sticky protocol violation flag
module set_bit_arbiter #(
   parameter int unsigned VAL_WIDTH = 64
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 hdr_req,
   input  logic                 cmp_req,
   input  logic                 hdr_done,
   input  logic                 cmp_done,
   input  logic                 hdr_enable,
   input  logic                 hdr_flush,
   input  logic                 cmp_enable,
   input  logic                 cmp_flush,
   input  logic [VAL_WIDTH-1:0] hdr_val,
   input  logic [VAL_WIDTH-1:0] hdr_size_of_bit,
   input  logic [VAL_WIDTH-1:0] cmp_val,
   input  logic [VAL_WIDTH-1:0] cmp_size_of_bit,
   output logic                 hdr_grant,
   output logic                 cmp_grant,
   output logic                 sb_enable,
   output logic                 sb_flush,
   output logic [VAL_WIDTH-1:0] sb_val,
   output logic [VAL_WIDTH-1:0] sb_size_of_bit,
   output logic                 busy,
   output logic [31:0]          grant_bit_count,
   output logic                 protocol_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HDR   = 2'd1,
      CMP   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam logic [VAL_WIDTH-1:0] MAX_BITS = VAL_WIDTH'(64);

   // Reset: asserted asynchronously, released two rising edges later so the
   // first arbitration cannot happen before the second edge after release.
   logic sync_q1;
   logic rst_sync_n;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q1    <= 1'b0;
         rst_sync_n <= 1'b0;
      end else begin
         sync_q1    <= 1'b1;
         rst_sync_n <= sync_q1;
      end
   end

   state_t                 state;
   state_t                 next_state;
   logic                   own_en;
   logic                   own_flush;
   logic [VAL_WIDTH-1:0]   own_val;
   logic [VAL_WIDTH-1:0]   own_size;
   logic                   size_ok;
   logic                   accept;
   logic                   bad_size;
   logic                   stray;
   logic                   pick_hdr;
   logic [32:0]            cnt_sum;

`ifdef SET_BIT_ARB_ROUND_ROBIN_EN
   logic last_cmp;   // 1: component was the last owner
   assign pick_hdr = last_cmp;
`else
   assign pick_hdr = 1'b1;
`endif

   always_comb begin
      own_en    = 1'b0;
      own_flush = 1'b0;
      own_val   = '0;
      own_size  = '0;
      unique case (state)
         HDR: begin
            own_en    = hdr_enable;
            own_flush = hdr_flush;
            own_val   = hdr_val;
            own_size  = hdr_size_of_bit;
         end
         CMP: begin
            own_en    = cmp_enable;
            own_flush = cmp_flush;
            own_val   = cmp_val;
            own_size  = cmp_size_of_bit;
         end
         default: ;
      endcase

      size_ok  = (own_size != '0) && (own_size <= MAX_BITS);
      // An illegal size on the enable drops the whole beat, including a
      // flush raised in the same cycle.
      accept   = (own_en || own_flush) && (!own_en || size_ok);
      bad_size = own_en && !size_ok;
      stray    = ((hdr_enable || hdr_flush) && (state != HDR)) ||
                 ((cmp_enable || cmp_flush) && (state != CMP));

      // Only reached with size in 1..64, so the low 7 bits carry the value.
      cnt_sum  = {1'b0, grant_bit_count} + 33'(own_size[6:0]);

      next_state = state;
      unique case (state)
         IDLE: begin
            if (hdr_req && cmp_req) next_state = pick_hdr ? HDR : CMP;
            else if (hdr_req)       next_state = HDR;
            else if (cmp_req)       next_state = CMP;
         end
         HDR:     if (hdr_done) next_state = DRAIN;
         CMP:     if (cmp_done) next_state = DRAIN;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state           <= IDLE;
         hdr_grant       <= 1'b0;
         cmp_grant       <= 1'b0;
         busy            <= 1'b0;
         sb_enable       <= 1'b0;
         sb_flush        <= 1'b0;
         sb_val          <= '0;
         sb_size_of_bit  <= '0;
         grant_bit_count <= '0;
         protocol_err    <= 1'b0;
`ifdef SET_BIT_ARB_ROUND_ROBIN_EN
         last_cmp        <= 1'b1;
`endif
      end else begin
         state     <= next_state;
         hdr_grant <= (next_state == HDR);
         cmp_grant <= (next_state == CMP);
         busy      <= (next_state != IDLE);

         sb_enable      <= accept && own_en;
         sb_flush       <= accept && own_flush;
         sb_val         <= accept ? own_val  : '0;
         sb_size_of_bit <= accept ? own_size : '0;

         if (stray || bad_size) protocol_err <= 1'b1;

         if ((state == IDLE) && (next_state != IDLE))
            grant_bit_count <= '0;
         else if (accept && own_en)
            grant_bit_count <= cnt_sum[32] ? '1 : cnt_sum[31:0];

`ifdef SET_BIT_ARB_ROUND_ROBIN_EN
         if ((state == IDLE) && (next_state != IDLE))
            last_cmp <= (next_state == CMP);
`endif
      end
   end

endmodule

// File: tb/tb_set_bit_arbiter.sv
// Directed bench for set_bit_arbiter: grant timing, write forwarding,
// tie arbitration, protocol errors, done-with-write and mid-grant reset.
module tb_set_bit_arbiter;

   localparam int unsigned W = 64;

`ifdef SET_BIT_ARB_ROUND_ROBIN_EN
   // The first transaction is owned by the header, so a tie goes to component.
   localparam logic TIE_HDR_FIRST = 1'b0;
`else
   localparam logic TIE_HDR_FIRST = 1'b1;
`endif

   logic         clock = 1'b0;
   logic         reset_n = 1'b1;
   logic         hdr_req = 1'b0, cmp_req = 1'b0;
   logic         hdr_done = 1'b0, cmp_done = 1'b0;
   logic         hdr_enable = 1'b0, hdr_flush = 1'b0;
   logic         cmp_enable = 1'b0, cmp_flush = 1'b0;
   logic [W-1:0] hdr_val = '0, hdr_size_of_bit = '0;
   logic [W-1:0] cmp_val = '0, cmp_size_of_bit = '0;
   logic         hdr_grant, cmp_grant, sb_enable, sb_flush, busy, protocol_err;
   logic [W-1:0] sb_val, sb_size_of_bit;
   logic [31:0]  grant_bit_count;

   int checks = 0;
   int errors = 0;

   set_bit_arbiter #(.VAL_WIDTH(W)) dut (
      .clock(clock), .reset_n(reset_n),
      .hdr_req(hdr_req), .cmp_req(cmp_req),
      .hdr_done(hdr_done), .cmp_done(cmp_done),
      .hdr_enable(hdr_enable), .hdr_flush(hdr_flush),
      .cmp_enable(cmp_enable), .cmp_flush(cmp_flush),
      .hdr_val(hdr_val), .hdr_size_of_bit(hdr_size_of_bit),
      .cmp_val(cmp_val), .cmp_size_of_bit(cmp_size_of_bit),
      .hdr_grant(hdr_grant), .cmp_grant(cmp_grant),
      .sb_enable(sb_enable), .sb_flush(sb_flush),
      .sb_val(sb_val), .sb_size_of_bit(sb_size_of_bit),
      .busy(busy), .grant_bit_count(grant_bit_count),
      .protocol_err(protocol_err)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // ---- reset state
      reset_n = 1'b0;
      #12;
      check("rst_hdr_grant", 64'(hdr_grant), 64'(0));
      check("rst_cmp_grant", 64'(cmp_grant), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_sb_enable", 64'(sb_enable), 64'(0));
      check("rst_count", 64'(grant_bit_count), 64'(0));
      check("rst_err", 64'(protocol_err), 64'(0));

      // ---- release with hdr_req already high: no grant before the third edge
      tick();
      reset_n = 1'b1;
      hdr_req = 1'b1;
      tick();
      check("sync_edge1_grant", 64'(hdr_grant), 64'(0));
      tick();
      check("sync_edge2_grant", 64'(hdr_grant), 64'(0));
      tick();
      check("hdr_grant_on", 64'(hdr_grant), 64'(1));
      check("hdr_busy_on", 64'(busy), 64'(1));
      check("hdr_count_clear", 64'(grant_bit_count), 64'(0));

      // ---- three header writes: 32, 16, 8
      hdr_enable = 1'b1; hdr_size_of_bit = 64'd32; hdr_val = 64'h11;
      tick();
      check("w1_sb_enable", 64'(sb_enable), 64'(1));
      check("w1_sb_size", sb_size_of_bit, 64'd32);
      check("w1_sb_val", sb_val, 64'h11);
      hdr_size_of_bit = 64'd16; hdr_val = 64'h22;
      tick();
      check("w2_sb_enable", 64'(sb_enable), 64'(1));
      check("w2_sb_size", sb_size_of_bit, 64'd16);
      hdr_size_of_bit = 64'd8; hdr_val = 64'h33;
      tick();
      check("w3_sb_enable", 64'(sb_enable), 64'(1));
      check("w3_sb_val", sb_val, 64'h33);
      hdr_enable = 1'b0; hdr_done = 1'b1; hdr_req = 1'b0;
      tick();
      check("drain_sb_enable", 64'(sb_enable), 64'(0));
      check("drain_sb_val", sb_val, 64'h0);
      check("drain_hdr_grant", 64'(hdr_grant), 64'(0));
      check("drain_busy", 64'(busy), 64'(1));
      check("hdr_count_56", 64'(grant_bit_count), 64'd56);
      hdr_done = 1'b0;
      tick();
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_count_hold", 64'(grant_bit_count), 64'd56);
      check("no_err_yet", 64'(protocol_err), 64'(0));

      // ---- simultaneous requests
      hdr_req = 1'b1; cmp_req = 1'b1;
      tick();
      check("tie1_hdr_grant", 64'(hdr_grant), 64'(TIE_HDR_FIRST));
      check("tie1_cmp_grant", 64'(cmp_grant), 64'(!TIE_HDR_FIRST));
      check("tie1_count_clear", 64'(grant_bit_count), 64'(0));
      if (TIE_HDR_FIRST) begin hdr_done = 1'b1; hdr_req = 1'b0; end
      else begin cmp_done = 1'b1; cmp_req = 1'b0; end
      tick();
      check("tie_drain_hdr", 64'(hdr_grant), 64'(0));
      check("tie_drain_cmp", 64'(cmp_grant), 64'(0));
      check("tie_drain_busy", 64'(busy), 64'(1));
      hdr_done = 1'b0; cmp_done = 1'b0;
      tick();
      check("tie_idle_busy", 64'(busy), 64'(0));
      check("tie_idle_cmp", 64'(cmp_grant), 64'(0));
      tick();
      check("tie2_hdr_grant", 64'(hdr_grant), 64'(!TIE_HDR_FIRST));
      check("tie2_cmp_grant", 64'(cmp_grant), 64'(TIE_HDR_FIRST));
      hdr_req = 1'b0; cmp_req = 1'b0; hdr_done = 1'b1; cmp_done = 1'b1;
      tick();
      hdr_done = 1'b0; cmp_done = 1'b0;
      tick();
      check("tie_end_busy", 64'(busy), 64'(0));

      // ---- oversize enable from the owner
      cmp_req = 1'b1;
      tick();
      check("cmp_grant_on", 64'(cmp_grant), 64'(1));
      cmp_enable = 1'b1; cmp_size_of_bit = 64'd10; cmp_val = 64'hA;
      tick();
      check("c10_sb_enable", 64'(sb_enable), 64'(1));
      check("c10_count", 64'(grant_bit_count), 64'd10);
      check("c10_err", 64'(protocol_err), 64'(0));
      cmp_size_of_bit = 64'd65;
      tick();
      check("c65_sb_enable", 64'(sb_enable), 64'(0));
      check("c65_err", 64'(protocol_err), 64'(1));
      check("c65_count", 64'(grant_bit_count), 64'd10);
      check("c65_grant", 64'(cmp_grant), 64'(1));

      // ---- reset during CMP with a write on the bus
      cmp_size_of_bit = 64'd5; cmp_val = 64'h5;
      tick();
      check("c5_sb_enable", 64'(sb_enable), 64'(1));
      check("c5_count", 64'(grant_bit_count), 64'd15);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_grant", 64'(cmp_grant), 64'(0));
      check("mid_rst_sb_enable", 64'(sb_enable), 64'(0));
      check("mid_rst_sb_size", sb_size_of_bit, 64'h0);
      check("mid_rst_busy", 64'(busy), 64'(0));
      check("mid_rst_count", 64'(grant_bit_count), 64'(0));
      check("mid_rst_err", 64'(protocol_err), 64'(0));
      cmp_req = 1'b0; cmp_enable = 1'b0; cmp_size_of_bit = '0; cmp_val = '0;
      tick();
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_sb_enable", 64'(sb_enable), 64'(0));
         check("post_rst_grant", 64'(cmp_grant), 64'(0));
      end

      // ---- component write racing a stray header write
      cmp_req = 1'b1;
      tick();
      check("cmp2_grant", 64'(cmp_grant), 64'(1));
      check("cmp2_err_clear", 64'(protocol_err), 64'(0));
      cmp_enable = 1'b1; cmp_size_of_bit = 64'd64; cmp_val = 64'hDEADBEEF;
      hdr_enable = 1'b1; hdr_size_of_bit = 64'd8; hdr_val = 64'h55;
      tick();
      check("race_sb_enable", 64'(sb_enable), 64'(1));
      check("race_sb_val", sb_val, 64'hDEADBEEF);
      check("race_sb_size", sb_size_of_bit, 64'd64);
      check("race_err", 64'(protocol_err), 64'(1));
      check("race_count", 64'(grant_bit_count), 64'd64);
      hdr_enable = 1'b0; hdr_size_of_bit = '0; hdr_val = '0;

      // ---- done together with enable + flush
      cmp_flush = 1'b1; cmp_size_of_bit = 64'd7; cmp_val = 64'h7F;
      cmp_done = 1'b1; cmp_req = 1'b0;
      tick();
      check("last_sb_enable", 64'(sb_enable), 64'(1));
      check("last_sb_flush", 64'(sb_flush), 64'(1));
      check("last_sb_size", sb_size_of_bit, 64'd7);
      check("last_count", 64'(grant_bit_count), 64'd71);
      check("last_grant_off", 64'(cmp_grant), 64'(0));
      check("last_drain_busy", 64'(busy), 64'(1));
      cmp_enable = 1'b0; cmp_flush = 1'b0; cmp_done = 1'b0;
      cmp_size_of_bit = '0; cmp_val = '0;
      tick();
      check("end_busy", 64'(busy), 64'(0));
      check("end_sb_enable", 64'(sb_enable), 64'(0));
      check("end_sb_flush", 64'(sb_flush), 64'(0));
      check("end_count", 64'(grant_bit_count), 64'd71);
      check("end_err_sticky", 64'(protocol_err), 64'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/set_bit_arbiter.md
SET_BIT_ARBITER -- requirements
Module: set_bit_arbiter

Interface
REQ-001 SHALL have parameter VAL_WIDTH, default 64, width of val/size_of_bit buses.
REQ-002 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-003 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have: hdr_req / cmp_req  in  1 each  header / component requests ownership of set_bit.
REQ-005 SHALL have: hdr_done / cmp_done  in  1 each  owner releases ownership.
REQ-006 SHALL have: hdr_enable, hdr_flush, cmp_enable, cmp_flush  in  1 each  write strobe / flush strobe.
REQ-007 SHALL have: hdr_val, hdr_size_of_bit, cmp_val, cmp_size_of_bit  in  VAL_WIDTH each  write payload / bit count.
REQ-008 SHALL have: hdr_grant / cmp_grant  out  1 each  ownership indication.
REQ-009 SHALL have: sb_enable, sb_flush  out  1 each; sb_val, sb_size_of_bit  out  VAL_WIDTH each  registered drive to set_bit.
REQ-010 SHALL have: busy  out  1  state != IDLE; grant_bit_count  out  32  bits accepted under current/last grant; protocol_err  out  1  sticky error.

Function
REQ-011 SHALL implement FSM states IDLE, HDR, CMP, DRAIN; hdr_grant=1 only in HDR, cmp_grant=1 only in CMP.
REQ-012 IDLE: if any req, SHALL move to HDR or CMP per arbitration (REQ-022); grant visible the cycle after req is sampled.
REQ-013 HDR/CMP: owner's done sampled high -> DRAIN; req deassertion without done SHALL NOT release grant.
REQ-014 DRAIN: SHALL last exactly one cycle, then IDLE; no grant asserted; guarantees final registered write reaches set_bit before next owner.
REQ-015 Accepted write = owner's enable or flush high while its grant high; SHALL appear on sb_* exactly one cycle later, sb_* = 0 otherwise.
REQ-016 enable and flush both high same cycle: SHALL forward both strobes unchanged (set_bit flushes after write).
REQ-017 done high with enable/flush same cycle: write SHALL be accepted, then release.
REQ-018 enable/flush from non-owner, or from either requester in IDLE/DRAIN: SHALL be dropped and set protocol_err.
REQ-019 Owner enable with size_of_bit > 64 or == 0: SHALL be dropped and set protocol_err.
REQ-020 grant_bit_count SHALL clear to 0 on entry to HDR/CMP, add size_of_bit per accepted enable (flush adds 0), saturate at 0xFFFFFFFF, hold value through DRAIN/IDLE.
REQ-021 protocol_err SHALL remain set until reset.
REQ-022 Arbitration in IDLE: fixed priority header over component (see REQ-026).

Reset
REQ-023 reset_n low SHALL asynchronously force IDLE, all grants 0, sb_* 0, busy 0, grant_bit_count 0, protocol_err 0, last-owner register = component.
REQ-024 Reset mid-grant SHALL discard any pending registered write; no sb_enable pulse after reset release until a new grant.
REQ-025 Deassertion SHALL be synchronised internally; first arbitration no earlier than the second rising edge after release.

Configuration
REQ-026 Macro SET_BIT_ARB_ROUND_ROBIN_EN: defined -> simultaneous requests in IDLE SHALL grant the requester that was not the last owner; last-owner updates on each grant. Undefined -> fixed header priority, last-owner register absent.

Verification
REQ-027 hdr_req=1 alone; 3 writes size 32,16,8; hdr_done -> hdr_grant 1 cycle after req, sb_enable 3 pulses each 1 cycle delayed, grant_bit_count=56, DRAIN 1 cycle, busy low after.
REQ-028 hdr_req and cmp_req same cycle, fixed build -> HDR first; after hdr_done, DRAIN, IDLE, then CMP. Round-robin build after reset -> HDR first (last owner=component), next tie -> CMP.
REQ-029 cmp owner writes size 64, val 0xDEADBEEF, hdr_enable same cycle -> sb_val=0xDEADBEEF, sb_size_of_bit=64, header write dropped, protocol_err=1.
REQ-030 Owner enable with size_of_bit=65 -> no sb_enable, protocol_err=1, grant_bit_count unchanged.
REQ-031 cmp_done with cmp_enable+cmp_flush size 7 same cycle -> sb_enable=sb_flush=1 next cycle, grant_bit_count+7, then DRAIN.
REQ-032 reset_n low during CMP with write in flight -> grants, sb_* drop immediately; no sb_enable after release until a new request is granted.
